cfix_mac: RTL and testbench
===========================

# cfix_mac

Pipelined complex fixed-point multiply-accumulate unit: the parametrised successor to the two-operand complex add/mult primitive. It accepts a stream of complex operand pairs with frame markers and accumulates their products, optionally conjugating B, with guard bits and a per-frame term count. It serves as the dot-product/FIR tap engine in the filter datapath.

## Interface
- n_int, 8, integer bits (excluding sign)
- n_mant, 23, fractional bits; word width W = n_int+n_mant+1, two's complement
- ACC_GUARD, 4, extra accumulator MSBs; accumulator width WA = W+ACC_GUARD
- MAX_TERMS, 64, count ceiling; count width CW = $clog2(MAX_TERMS+1)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand pair present this cycle
- in_first  in  1  qualifies in_valid; this term starts a new frame
- in_last  in  1  qualifies in_valid; this term ends the frame
- conj_b  in  1  qualifies in_valid; use conj(B)
- AR, AI, BR, BI  in  W each  signed operands
- out_valid  out  1  one-cycle pulse, frame result valid
- resultR, resultI  out  W each  frame result, held until next out_valid
- out_count  out  CW  number of terms in reported frame
- out_ovf  out  1  frame overflowed W (sticky per frame, held with result)

## Operation
- No backpressure; a term is accepted every cycle in_valid=1.
- Stage P1: register four full products AR·BR, AI·BI, AI·BR, AR·BI (2W bits each) plus valid, first, last, conj.
- Stage P2: conj=0: re = RR−II, im = IR+RI; conj=1: re = RR+II, im = IR−RI (2W+1 bits). Arithmetic shift right by n_mant (floor), sign-extend/truncate to WA.
- Stage P3 (accumulate): first=1 loads acc = term, count = 1; else acc += term (wraps at WA), count += 1, saturating at MAX_TERMS. Valid term with no first after reset adds to zeroed acc.
- Overflow flag: set if any P3 acc value (either component) is outside the W-bit signed range; cleared on first.
- On last: output stage converts acc to W bits and asserts out_valid next cycle; first and last together = single-term frame.
- Non-valid cycles: pipeline bubbles, acc and count unchanged.

## Timing
- Latency: input accepted at cycle t with in_last=1 → out_valid high at t+3 (P1 t+1, P2 t+2, acc/out t+3).
- Throughput: one term per cycle; back-to-back frames (last at t, first at t+1) produce out_valid at t+3 and next frame unaffected.
- out_valid never high two cycles running unless frames are single-term back-to-back.
- Reset (asynchronous, any time including mid-frame): all pipeline valids, acc, count, ovf = 0; out_valid=0, resultR=resultI=0, out_count=0, out_ovf=0. In-flight terms discarded; no out_valid for the interrupted frame.

## Configuration
- CFIX_MAC_SAT_EN defined: on output conversion, acc values above max W-bit value clamp to 2^(W−1)−1, below min clamp to −2^(W−1), per component.
- Undefined: output takes the low W bits of acc (wrap). out_ovf behaves identically in both builds.

## Test plan
Use n_int=3, n_mant=4 (W=8, 1.0=16), ACC_GUARD=4.
- Single term first=last=1, A=(16,32), B=(48,−16), conj=0 → at t+3 out_valid, result (80,80), count 1, ovf 0.
- Same operands conj=1 → result (16,112).
- Three terms A=(16,0), B=(32,0) → result (96,0), count 3, one out_valid pulse.
- Four such terms → acc 128: SAT build result (127,0), wrap build (−128,0); ovf 1 both.
- Assert rst after second of three terms → all outputs 0 immediately, no out_valid; new frame after release correct.
- Back-to-back single-term frames every cycle for 10 cycles with random operands → 10 consecutive out_valid pulses matching reference model, count 1 each.

Source files
------------

// File: rtl/cfix_mac.sv
// cfix_mac -- pipelined complex fixed-point multiply-accumulate.
//
// Accepts one complex operand pair (A, B) per cycle. It forms A*B, or
// A*conj(B) when conj_b is set, rescales the product back to the operand
// format, and accumulates it into a guard-extended accumulator. A frame runs
// from in_first to in_last. One cycle after the last term is accumulated, the
// frame result is presented with its term count and a sticky overflow flag.
//
// Pipeline: P1 (products) -> P2 (combine + rescale) -> P3 (accumulate/output).
// A term accepted with in_last at cycle t reports out_valid at cycle t+3.
//
// Build option: define CFIX_MAC_SAT_EN to clamp the reported result to the
// W-bit signed range. When it is undefined, the low W bits are taken (wrap).
// out_ovf behaves the same way in both builds.

module cfix_mac #(
  parameter int n_int     = 8,
  parameter int n_mant    = 23,
  parameter int ACC_GUARD = 4,
  parameter int MAX_TERMS = 64,
  localparam int W  = n_int + n_mant + 1,
  localparam int WA = W + ACC_GUARD,
  localparam int CW = $clog2(MAX_TERMS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic                in_first,
  input  logic                in_last,
  input  logic                conj_b,
  input  logic signed [W-1:0] AR,
  input  logic signed [W-1:0] AI,
  input  logic signed [W-1:0] BR,
  input  logic signed [W-1:0] BI,
  output logic                out_valid,
  output logic signed [W-1:0] resultR,
  output logic signed [W-1:0] resultI,
  output logic [CW-1:0]       out_count,
  output logic                out_ovf
);

  // Bounds of the W-bit signed range, expressed at accumulator width.
  localparam logic signed [WA-1:0] word_max = {{(ACC_GUARD + 1){1'b0}}, {(W - 1){1'b1}}};
  localparam logic signed [WA-1:0] word_min = {{(ACC_GUARD + 1){1'b1}}, {(W - 1){1'b0}}};
  localparam logic [CW-1:0]        max_count = CW'(MAX_TERMS);
  localparam logic [CW-1:0]        one_count = {{(CW - 1){1'b0}}, 1'b1};

  // True when an accumulator value cannot be represented in W signed bits.
  function automatic logic out_of_range(input logic signed [WA-1:0] v);
    out_of_range = (v > word_max) || (v < word_min);
  endfunction

  // Narrow an accumulator value to the W-bit result format.
  function automatic logic signed [W-1:0] to_word(input logic signed [WA-1:0] v);
`ifdef CFIX_MAC_SAT_EN
    if (v > word_max) begin
      to_word = {1'b0, {(W - 1){1'b1}}};
    end else if (v < word_min) begin
      to_word = {1'b1, {(W - 1){1'b0}}};
    end else begin
      to_word = W'(v);
    end
`else
    to_word = W'(v);
`endif
  endfunction

  // ---------------------------------------------------------------- P1 ----
  logic signed [2*W-1:0] ar_ext_s, ai_ext_s, br_ext_s, bi_ext_s;
  logic signed [2*W-1:0] prod_rr_s, prod_ii_s, prod_ir_s, prod_ri_s;

  logic                  p1_valid_r, p1_first_r, p1_last_r, p1_conj_r;
  logic signed [2*W-1:0] p1_rr_r, p1_ii_r, p1_ir_r, p1_ri_r;

  // Full-precision partial products; operands widened so each product keeps all 2W bits.
  always_comb begin
    ar_ext_s  = {{W{AR[W-1]}}, AR};
    ai_ext_s  = {{W{AI[W-1]}}, AI};
    br_ext_s  = {{W{BR[W-1]}}, BR};
    bi_ext_s  = {{W{BI[W-1]}}, BI};
    prod_rr_s = ar_ext_s * br_ext_s;
    prod_ii_s = ai_ext_s * bi_ext_s;
    prod_ir_s = ai_ext_s * br_ext_s;
    prod_ri_s = ar_ext_s * bi_ext_s;
  end

  // P1 register: products and term control; frame markers only count with a valid term.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1_valid_r <= 1'b0;
      p1_first_r <= 1'b0;
      p1_last_r  <= 1'b0;
      p1_conj_r  <= 1'b0;
      p1_rr_r    <= {(2 * W){1'b0}};
      p1_ii_r    <= {(2 * W){1'b0}};
      p1_ir_r    <= {(2 * W){1'b0}};
      p1_ri_r    <= {(2 * W){1'b0}};
    end else begin
      p1_valid_r <= in_valid;
      p1_first_r <= in_valid & in_first;
      p1_last_r  <= in_valid & in_last;
      p1_conj_r  <= in_valid & conj_b;
      p1_rr_r    <= prod_rr_s;
      p1_ii_r    <= prod_ii_s;
      p1_ir_r    <= prod_ir_s;
      p1_ri_r    <= prod_ri_s;
    end
  end

  // ---------------------------------------------------------------- P2 ----
  logic signed [2*W:0]   rr_x_s, ii_x_s, ir_x_s, ri_x_s;
  logic signed [2*W:0]   re_sum_s, im_sum_s;
  logic signed [WA-1:0]  re_term_s, im_term_s;

  logic                  p2_valid_r, p2_first_r, p2_last_r;
  logic signed [WA-1:0]  p2_re_r, p2_im_r;

  // Combine products (conjugating B on request), floor-rescale by n_mant, fit to WA bits.
  always_comb begin
    rr_x_s = {p1_rr_r[2*W-1], p1_rr_r};
    ii_x_s = {p1_ii_r[2*W-1], p1_ii_r};
    ir_x_s = {p1_ir_r[2*W-1], p1_ir_r};
    ri_x_s = {p1_ri_r[2*W-1], p1_ri_r};
    if (p1_conj_r) begin
      re_sum_s = rr_x_s + ii_x_s;
      im_sum_s = ir_x_s - ri_x_s;
    end else begin
      re_sum_s = rr_x_s - ii_x_s;
      im_sum_s = ir_x_s + ri_x_s;
    end
    re_term_s = WA'(re_sum_s >>> n_mant);
    im_term_s = WA'(im_sum_s >>> n_mant);
  end

  // P2 register: rescaled term ready for accumulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p2_valid_r <= 1'b0;
      p2_first_r <= 1'b0;
      p2_last_r  <= 1'b0;
      p2_re_r    <= {WA{1'b0}};
      p2_im_r    <= {WA{1'b0}};
    end else begin
      p2_valid_r <= p1_valid_r;
      p2_first_r <= p1_first_r;
      p2_last_r  <= p1_last_r;
      p2_re_r    <= re_term_s;
      p2_im_r    <= im_term_s;
    end
  end

  // ---------------------------------------------------------------- P3 ----
  logic signed [WA-1:0] acc_re_r, acc_im_r;
  logic [CW-1:0]        count_r;
  logic                 ovf_r;

  logic signed [WA-1:0] acc_re_next_s, acc_im_next_s;
  logic [CW-1:0]        count_next_s;
  logic                 ovf_next_s;

  logic                 out_valid_r;
  logic signed [W-1:0]  result_re_r, result_im_r;
  logic [CW-1:0]        out_count_r;
  logic                 out_ovf_r;

  // Next accumulator state: a first term restarts the frame, others add with WA-bit wrap.
  always_comb begin
    if (p2_first_r) begin
      acc_re_next_s = p2_re_r;
      acc_im_next_s = p2_im_r;
      count_next_s  = one_count;
    end else begin
      acc_re_next_s = acc_re_r + p2_re_r;
      acc_im_next_s = acc_im_r + p2_im_r;
      if (count_r >= max_count) begin
        count_next_s = max_count;
      end else begin
        count_next_s = count_r + one_count;
      end
    end
    ovf_next_s = (p2_first_r ? 1'b0 : ovf_r)
               | out_of_range(acc_re_next_s)
               | out_of_range(acc_im_next_s);
  end

  // Accumulator state; bubbles leave it untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_re_r <= {WA{1'b0}};
      acc_im_r <= {WA{1'b0}};
      count_r  <= {CW{1'b0}};
      ovf_r    <= 1'b0;
    end else if (p2_valid_r) begin
      acc_re_r <= acc_re_next_s;
      acc_im_r <= acc_im_next_s;
      count_r  <= count_next_s;
      ovf_r    <= ovf_next_s;
    end
  end

  // Result registers: capture the closing frame alongside its last accumulation, hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      result_re_r <= {W{1'b0}};
      result_im_r <= {W{1'b0}};
      out_count_r <= {CW{1'b0}};
      out_ovf_r   <= 1'b0;
    end else begin
      out_valid_r <= p2_valid_r & p2_last_r;
      if (p2_valid_r & p2_last_r) begin
        result_re_r <= to_word(acc_re_next_s);
        result_im_r <= to_word(acc_im_next_s);
        out_count_r <= count_next_s;
        out_ovf_r   <= ovf_next_s;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign resultR   = result_re_r;
  assign resultI   = result_im_r;
  assign out_count = out_count_r;
  assign out_ovf   = out_ovf_r;

endmodule

// File: tb/tb_cfix_mac.sv
// Self-checking bench for cfix_mac at W=8 (n_int=3, n_mant=4, 1.0 = 16),
// ACC_GUARD=4, MAX_TERMS=64. Expected results come from an integer model of
// the complex MAC written directly from the arithmetic rules.

module tb_cfix_mac;

  localparam int N_INT  = 3;
  localparam int N_MANT = 4;
  localparam int GUARD  = 4;
  localparam int MAXT   = 64;
  localparam int W      = N_INT + N_MANT + 1;
  localparam int WA     = W + GUARD;
  localparam int CW     = $clog2(MAXT + 1);

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid, in_first, in_last, conj_b;
  logic signed [W-1:0] AR, AI, BR, BI;
  logic                out_valid;
  logic signed [W-1:0] resultR, resultI;
  logic [CW-1:0]       out_count;
  logic                out_ovf;

  int checks   = 0;
  int failures = 0;

  // Stimulus table and per-term expected outputs (visible three cycles after the term).
  int st_valid[128], st_first[128], st_last[128], st_conj[128];
  int st_ar[128], st_ai[128], st_br[128], st_bi[128];
  int ex_v[128], ex_r[128], ex_i[128], ex_c[128], ex_o[128];

  // Reference model state: running frame sums and the currently reported result.
  int m_re, m_im, m_cnt, m_ovf;
  int h_r, h_i, h_c, h_o;

  cfix_mac #(.n_int(N_INT), .n_mant(N_MANT), .ACC_GUARD(GUARD), .MAX_TERMS(MAXT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_first(in_first), .in_last(in_last), .conj_b(conj_b),
    .AR(AR), .AI(AI), .BR(BR), .BI(BI),
    .out_valid(out_valid), .resultR(resultR), .resultI(resultI),
    .out_count(out_count), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  // Value of x reduced into the two's-complement range of the given width.
  function automatic int wrapn(input int x, input int bits);
    int m, r;
    m = 1 << bits;
    r = ((x % m) + m) % m;
    if (r >= m / 2) r = r - m;
    return r;
  endfunction

  function automatic int fits_word(input int x);
    return (x <= 127 && x >= -128) ? 1 : 0;
  endfunction

  function automatic int to_out(input int x);
`ifdef CFIX_MAC_SAT_EN
    if (x > 127) return 127;
    if (x < -128) return -128;
    return x;
`else
    return wrapn(x, W);
`endif
  endfunction

  function automatic int rnd(input int lo, input int hi);
    return lo + int'($urandom_range(0, hi - lo));
  endfunction

  task automatic model_reset();
    m_re = 0; m_im = 0; m_cnt = 0; m_ovf = 0;
    h_r = 0; h_i = 0; h_c = 0; h_o = 0;
  endtask

  task automatic clear_stim(input int n);
    for (int k = 0; k < n; k++) begin
      st_valid[k] = 0; st_first[k] = 0; st_last[k] = 0; st_conj[k] = 0;
      st_ar[k] = 0; st_ai[k] = 0; st_br[k] = 0; st_bi[k] = 0;
    end
  endtask

  task automatic set_term(input int k, input int f, input int l, input int c,
                          input int ar, input int ai, input int br, input int bi);
    st_valid[k] = 1; st_first[k] = f; st_last[k] = l; st_conj[k] = c;
    st_ar[k] = ar; st_ai[k] = ai; st_br[k] = br; st_bi[k] = bi;
  endtask

  // Run the model over terms 0..n-1 and record what the DUT should show for each.
  task automatic model_run(input int n);
    int re, im;
    for (int k = 0; k < n; k++) begin
      ex_v[k] = 0;
      if (st_valid[k] != 0) begin
        if (st_conj[k] != 0) begin
          re = st_ar[k] * st_br[k] + st_ai[k] * st_bi[k];
          im = st_ai[k] * st_br[k] - st_ar[k] * st_bi[k];
        end else begin
          re = st_ar[k] * st_br[k] - st_ai[k] * st_bi[k];
          im = st_ai[k] * st_br[k] + st_ar[k] * st_bi[k];
        end
        re = wrapn(re >>> N_MANT, WA);
        im = wrapn(im >>> N_MANT, WA);
        if (st_first[k] != 0) begin
          m_re = re; m_im = im; m_cnt = 1; m_ovf = 0;
        end else begin
          m_re = wrapn(m_re + re, WA);
          m_im = wrapn(m_im + im, WA);
          m_cnt = (m_cnt < MAXT) ? m_cnt + 1 : MAXT;
        end
        if (fits_word(m_re) == 0 || fits_word(m_im) == 0) m_ovf = 1;
        if (st_last[k] != 0) begin
          h_r = to_out(m_re); h_i = to_out(m_im); h_c = m_cnt; h_o = m_ovf;
          ex_v[k] = 1;
        end
      end
      ex_r[k] = h_r; ex_i[k] = h_i; ex_c[k] = h_c; ex_o[k] = h_o;
    end
  endtask

  task automatic drive_term(input int k);
    in_valid = st_valid[k][0];
    in_first = st_first[k][0];
    in_last  = st_last[k][0];
    conj_b   = st_conj[k][0];
    AR = 8'(st_ar[k]); AI = 8'(st_ai[k]); BR = 8'(st_br[k]); BI = 8'(st_bi[k]);
  endtask

  // Bubble: control and operands are randomised and must be ignored.
  task automatic drive_idle();
    in_valid = 1'b0;
    in_first = 1'($urandom_range(0, 1));
    in_last  = 1'($urandom_range(0, 1));
    conj_b   = 1'($urandom_range(0, 1));
    AR = 8'($urandom_range(0, 255)); AI = 8'($urandom_range(0, 255));
    BR = 8'($urandom_range(0, 255)); BI = 8'($urandom_range(0, 255));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1; in_first = 1'b1; in_last = 1'b1; conj_b = 1'b0;
      AR = 8'sd16; AI = 8'sd16; BR = 8'sd16; BI = 8'sd16;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || resultR !== 8'sd0 || resultI !== 8'sd0 ||
          out_count !== 7'd0 || out_ovf !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold cycle=%0d got v=%0b r=%0d i=%0d c=%0d o=%0b expected all zero",
                 c, out_valid, resultR, resultI, out_count, out_ovf);
      end
    end
    drive_idle();
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || out_count !== 7'd0) begin
        failures++;
        $display("FAIL reset_release cycle=%0d got v=%0b c=%0d expected v=0 c=0", c, out_valid, out_count);
      end
    end
    model_reset();
  endtask

  task automatic test_single();
    int j, n;
    n = 2;
    clear_stim(n);
    set_term(0, 1, 1, 0, 16, 32, 48, -16);
    set_term(1, 1, 1, 1, 16, 32, 48, -16);
    model_run(n);
    for (int i = 0; i < n + 2; i++) begin
      if (i < n) drive_term(i); else drive_idle();
      @(posedge clk); #1;
      if (i >= 2) begin
        j = i - 2;
        checks++;
        if (out_valid !== ex_v[j][0] || int'(resultR) !== ex_r[j] || int'(resultI) !== ex_i[j] ||
            int'(out_count) !== ex_c[j] || out_ovf !== ex_o[j][0]) begin
          failures++;
          $display("FAIL single j=%0d got v=%0b r=%0d i=%0d c=%0d o=%0b expected v=%0d r=%0d i=%0d c=%0d o=%0d",
                   j, out_valid, resultR, resultI, out_count, out_ovf, ex_v[j], ex_r[j], ex_i[j], ex_c[j], ex_o[j]);
        end
        checks++;
        if ((j == 0 && (int'(resultR) !== 80 || int'(resultI) !== 80 || out_count !== 7'd1 || out_ovf !== 1'b0)) ||
            (j == 1 && (int'(resultR) !== 16 || int'(resultI) !== 112 || out_count !== 7'd1 || out_ovf !== 1'b0))) begin
          failures++;
          $display("FAIL single_vector j=%0d got r=%0d i=%0d c=%0d o=%0b", j, resultR, resultI, out_count, out_ovf);
        end
      end
    end
  endtask

  task automatic test_accumulate();
    int j, n, exp4;
    n = 79;
    clear_stim(n);
    for (int k = 0; k < 3; k++) set_term(k, (k == 0) ? 1 : 0, (k == 2) ? 1 : 0, 0, 16, 0, 32, 0);
    for (int k = 4; k < 8; k++) set_term(k, (k == 4) ? 1 : 0, (k == 7) ? 1 : 0, 0, 16, 0, 32, 0);
    for (int k = 9; k < 79; k++)
      set_term(k, (k == 9) ? 1 : 0, (k == 78) ? 1 : 0, rnd(0, 1), rnd(-8, 8), rnd(-8, 8), rnd(-8, 8), rnd(-8, 8));
    model_run(n);
`ifdef CFIX_MAC_SAT_EN
    exp4 = 127;
`else
    exp4 = -128;
`endif
    for (int i = 0; i < n + 2; i++) begin
      if (i < n) drive_term(i); else drive_idle();
      @(posedge clk); #1;
      if (i >= 2) begin
        j = i - 2;
        checks++;
        if (out_valid !== ex_v[j][0] || int'(resultR) !== ex_r[j] || int'(resultI) !== ex_i[j] ||
            int'(out_count) !== ex_c[j] || out_ovf !== ex_o[j][0]) begin
          failures++;
          $display("FAIL accumulate j=%0d got v=%0b r=%0d i=%0d c=%0d o=%0b expected v=%0d r=%0d i=%0d c=%0d o=%0d",
                   j, out_valid, resultR, resultI, out_count, out_ovf, ex_v[j], ex_r[j], ex_i[j], ex_c[j], ex_o[j]);
        end
        checks++;
        if ((j == 2 && (int'(resultR) !== 96 || int'(resultI) !== 0 || out_count !== 7'd3 || out_ovf !== 1'b0)) ||
            (j == 7 && (int'(resultR) !== exp4 || int'(resultI) !== 0 || out_count !== 7'd4 || out_ovf !== 1'b1)) ||
            (j == 78 && (out_valid !== 1'b1 || out_count !== 7'd64))) begin
          failures++;
          $display("FAIL accumulate_vector j=%0d got v=%0b r=%0d i=%0d c=%0d o=%0b", j, out_valid, resultR, resultI, out_count, out_ovf);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int j, n;
    n = 10;
    clear_stim(n);
    for (int k = 0; k < n; k++)
      set_term(k, 1, 1, rnd(0, 1), rnd(-128, 127), rnd(-128, 127), rnd(-128, 127), rnd(-128, 127));
    model_run(n);
    for (int i = 0; i < n + 2; i++) begin
      if (i < n) drive_term(i); else drive_idle();
      @(posedge clk); #1;
      if (i >= 2) begin
        j = i - 2;
        checks++;
        if (out_valid !== 1'b1 || int'(resultR) !== ex_r[j] || int'(resultI) !== ex_i[j] ||
            out_count !== 7'd1 || out_ovf !== ex_o[j][0]) begin
          failures++;
          $display("FAIL back_to_back j=%0d got v=%0b r=%0d i=%0d c=%0d o=%0b expected v=1 r=%0d i=%0d c=1 o=%0d",
                   j, out_valid, resultR, resultI, out_count, out_ovf, ex_r[j], ex_i[j], ex_o[j]);
        end
      end
    end
  endtask

  task automatic test_random_frames();
    int j, n, len;
    n = 0;
    clear_stim(100);
    for (int f = 0; f < 8; f++) begin
      len = rnd(1, 5);
      for (int t = 0; t < len; t++) begin
        if (rnd(0, 3) == 0) n++;  // bubble inside or between frames
        set_term(n, (t == 0) ? 1 : 0, (t == len - 1) ? 1 : 0, rnd(0, 1),
                 rnd(-64, 63), rnd(-64, 63), rnd(-64, 63), rnd(-64, 63));
        n++;
      end
    end
    model_run(n);
    for (int i = 0; i < n + 2; i++) begin
      if (i < n) drive_term(i); else drive_idle();
      @(posedge clk); #1;
      if (i >= 2) begin
        j = i - 2;
        checks++;
        if (out_valid !== ex_v[j][0] || int'(resultR) !== ex_r[j] || int'(resultI) !== ex_i[j] ||
            int'(out_count) !== ex_c[j] || out_ovf !== ex_o[j][0]) begin
          failures++;
          $display("FAIL random_frames j=%0d got v=%0b r=%0d i=%0d c=%0d o=%0b expected v=%0d r=%0d i=%0d c=%0d o=%0d",
                   j, out_valid, resultR, resultI, out_count, out_ovf, ex_v[j], ex_r[j], ex_i[j], ex_c[j], ex_o[j]);
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    int j, n;
    // Two terms of a three-term frame, then reset while they are in flight.
    in_valid = 1'b1; in_first = 1'b1; in_last = 1'b0; conj_b = 1'b0;
    AR = 8'sd16; AI = 8'sd0; BR = 8'sd32; BI = 8'sd0;
    @(posedge clk); #1;
    in_first = 1'b0;
    @(posedge clk); #1;
    drive_idle();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || resultR !== 8'sd0 || resultI !== 8'sd0 ||
        out_count !== 7'd0 || out_ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_async got v=%0b r=%0d i=%0d c=%0d o=%0b expected all zero",
               out_valid, resultR, resultI, out_count, out_ovf);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || resultR !== 8'sd0 || out_count !== 7'd0) begin
        failures++;
        $display("FAIL reset_flush cycle=%0d got v=%0b r=%0d c=%0d expected 0", c, out_valid, resultR, out_count);
      end
    end
    @(negedge clk); rst = 1'b0;
    model_reset();
    n = 3;
    clear_stim(n);
    set_term(0, 0, 0, 0, 16, 0, 32, 0);  // no first: adds to the cleared accumulator
    set_term(1, 0, 1, 0, 16, 0, 32, 0);
    set_term(2, 1, 1, rnd(0, 1), rnd(-128, 127), rnd(-128, 127), rnd(-128, 127), rnd(-128, 127));
    model_run(n);
    for (int i = 0; i < n + 2; i++) begin
      if (i < n) drive_term(i); else drive_idle();
      @(posedge clk); #1;
      if (i >= 2) begin
        j = i - 2;
        checks++;
        if (out_valid !== ex_v[j][0] || int'(resultR) !== ex_r[j] || int'(resultI) !== ex_i[j] ||
            int'(out_count) !== ex_c[j] || out_ovf !== ex_o[j][0]) begin
          failures++;
          $display("FAIL after_reset j=%0d got v=%0b r=%0d i=%0d c=%0d o=%0b expected v=%0d r=%0d i=%0d c=%0d o=%0d",
                   j, out_valid, resultR, resultI, out_count, out_ovf, ex_v[j], ex_r[j], ex_i[j], ex_c[j], ex_o[j]);
        end
        checks++;
        if (j == 1 && (out_valid !== 1'b1 || int'(resultR) !== 64 || out_count !== 7'd2)) begin
          failures++;
          $display("FAIL after_reset_vector got v=%0b r=%0d c=%0d expected v=1 r=64 c=2", out_valid, resultR, out_count);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    model_reset();
    test_reset();
    test_single();
    test_accumulate();
    test_back_to_back();
    test_random_frames();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
